// File: rtl/digit_fb_pkg.sv
// Shared types and helpers for the 4-digit display image writer.
// State encoding, slot count and digit helpers used by writer and scanner.
package digit_fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int NUM_SLOTS = 4;

    // Digit codes at or above this have no glyph and render as background.
    localparam logic [3:0] BLANK_CODE = 4'd10;

    function automatic logic [3:0] slot_digit(
        input logic [15:0] bcd,
        input logic [1:0]  slot
    );
        logic [3:0] d;
        case (slot)
            2'd0:    d = bcd[15:12];
            2'd1:    d = bcd[11:8];
            2'd2:    d = bcd[7:4];
            default: d = bcd[3:0];
        endcase
        return d;
    endfunction

    function automatic logic [1:0] lowest_slot(input logic [3:0] mask);
        logic [1:0] s;
        if (mask[0])      s = 2'd0;
        else if (mask[1]) s = 2'd1;
        else if (mask[2]) s = 2'd2;
        else              s = 2'd3;
        return s;
    endfunction

endpackage

// File: rtl/digit_slot_scanner.sv
// Raster x/y walker over one glyph slot.
// Produces font ROM and image RAM addresses for the current pixel.
module digit_slot_scanner
    import digit_fb_pkg::*;
#(
    parameter int SLOT_W = 60,
    parameter int SLOT_H = 120,
    parameter int FB_AW  = 16,
    parameter int ROM_AW = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         en,
    input  logic [$clog2(NUM_SLOTS)-1:0] slot,
    input  logic [3:0]                   glyph,
    output logic [ROM_AW-1:0]            rom_addr,
    output logic [FB_AW-1:0]             fb_addr,
    output logic                         last_pixel
);

    localparam int SLOT_PIX = SLOT_W * SLOT_H;
    localparam int XW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int YW = (SLOT_H > 1) ? $clog2(SLOT_H) : 1;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_last, y_last;

    assign x_last     = (x_q == XW'(SLOT_W - 1));
    assign y_last     = (y_q == YW'(SLOT_H - 1));
    assign last_pixel = x_last && y_last;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign rom_addr = ROM_AW'(glyph) * ROM_AW'(SLOT_PIX)
                    + ROM_AW'(y_q) * ROM_AW'(SLOT_W)
                    + ROM_AW'(x_q);

    assign fb_addr = FB_AW'(slot) * FB_AW'(SLOT_PIX)
                   + FB_AW'(y_q) * FB_AW'(SLOT_W)
                   + FB_AW'(x_q);

endmodule

// File: rtl/digit_fb_writer.sv
// Renders a 4-digit BCD value into the display image RAM, one glyph slot
// at a time, skipping slots whose digit matches the last completed render.
module digit_fb_writer
    import digit_fb_pkg::*;
#(
    parameter int SLOT_W = 60,
    parameter int SLOT_H = 120,
    parameter int FB_AW  = 16,
    parameter int ROM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              force_all,
    input  logic [15:0]       bcd_in,
    input  logic [11:0]       fg_color,
    input  logic [11:0]       bg_color,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [11:0]       fb_wdata
);

    state_e      state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] cache_q, cache_d;
    logic        cache_inv_q, cache_inv_d;
    logic [11:0] fg_q, fg_d;
    logic [11:0] bg_q, bg_d;
    logic [3:0]  dirty_q, dirty_d;
    logic [1:0]  slot_q, slot_d;

    logic             fb_we_q;
    logic [FB_AW-1:0] fb_addr_q;
    logic             blank_q;

    logic [3:0]        load_dirty;
    logic [3:0]        rem_dirty;
    logic [3:0]        cur_digit;
    logic              cur_blank;
    logic              fill;
    logic              last_pixel;
    logic [ROM_AW-1:0] scan_rom;
    logic [FB_AW-1:0]  scan_fb;

    assign fill      = (state_q == ST_FILL);
    assign cur_digit = slot_digit(bcd_q, slot_q);
    assign cur_blank = (cur_digit >= BLANK_CODE);
    assign rem_dirty = dirty_q & ~(4'b0001 << slot_q);

    always_comb begin
        load_dirty = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            load_dirty[i] = force_all | cache_inv_q
                | (slot_digit(bcd_in, 2'(i)) != slot_digit(cache_q, 2'(i)));
        end
    end

    digit_slot_scanner #(
        .SLOT_W (SLOT_W),
        .SLOT_H (SLOT_H),
        .FB_AW  (FB_AW),
        .ROM_AW (ROM_AW)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .start      (!fill),
        .en         (fill),
        .slot       (slot_q),
        .glyph      (cur_digit),
        .rom_addr   (scan_rom),
        .fb_addr    (scan_fb),
        .last_pixel (last_pixel)
    );

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        cache_d     = cache_q;
        cache_inv_d = cache_inv_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        dirty_d     = dirty_q;
        slot_d      = slot_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bcd_d   = bcd_in;
                fg_d    = fg_color;
                bg_d    = bg_color;
                dirty_d = load_dirty;
                if (|load_dirty) begin
                    state_d = ST_FILL;
                    slot_d  = lowest_slot(load_dirty);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_FILL: begin
                if (last_pixel) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                dirty_d = rem_dirty;
                if (|rem_dirty) begin
                    state_d = ST_FILL;
                    slot_d  = lowest_slot(rem_dirty);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cache_d     = bcd_q;
                cache_inv_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bcd_q       <= '0;
            cache_q     <= '0;
            cache_inv_q <= 1'b1;
            fg_q        <= '0;
            bg_q        <= '0;
            dirty_q     <= '0;
            slot_q      <= '0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            cache_q     <= cache_d;
            cache_inv_q <= cache_inv_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            dirty_q     <= dirty_d;
            slot_q      <= slot_d;
        end
    end

    // Write stage lines up with rom_data, which returns one cycle after fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            blank_q   <= 1'b0;
        end else begin
            fb_we_q <= fill;
            blank_q <= cur_blank;
            if (fill) fb_addr_q <= scan_fb;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign rom_addr = (fill && !cur_blank) ? scan_rom : '0;
    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = !fb_we_q ? 12'h000
                    : (!blank_q && rom_data) ? fg_q : bg_q;

endmodule

// File: tb/tb_digit_fb_writer.sv
// Scoreboard bench for digit_fb_writer with a 4x2 glyph and 1-cycle ROM.
module tb_digit_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        force_all;
    logic [15:0] bcd_in;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic        busy;
    logic        done;
    logic [16:0] rom_addr;
    logic        rom_data = 1'b0;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [11:0] fb_wdata;

    digit_fb_writer #(
        .SLOT_W (4),
        .SLOT_H (2),
        .FB_AW  (16),
        .ROM_AW (17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .force_all (force_all),
        .bcd_in    (bcd_in),
        .fg_color  (fg_color),
        .bg_color  (bg_color),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [11:0] data;
        logic [16:0] rom;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    wr_t         wq[$];
    int          dq[$];
    wr_t         e;
    int          edone;
    logic [16:0] prev_rom = '0;

    function automatic logic font(input logic [16:0] a);
        return a[0] ^ a[2] ^ a[3] ^ a[5];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= font(rom_addr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h expected=none",
                         fb_addr);
            end else begin
                e = wq.pop_front();
                chk("fb_addr", 32'(fb_addr), 32'(e.addr));
                chk("fb_wdata", 32'(fb_wdata), 32'(e.data));
                chk("rom_addr", 32'(prev_rom), 32'(e.rom));
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%0d expected=none",
                         cyc - start_cyc);
            end else begin
                edone = dq.pop_front();
                chk("done_cycle", 32'(cyc - start_cyc), 32'(edone));
            end
            done_cnt++;
        end
        prev_rom = rom_addr;
    end

    task automatic push_slot(input int s, input logic [15:0] bcd,
                             input logic [11:0] fg, input logic [11:0] bg,
                             input int npix);
        int  d;
        wr_t w;
        d = int'((bcd >> (12 - 4 * s)) & 16'h000F);
        for (int p = 0; p < npix; p++) begin
            w.addr = 16'(s * 8 + p);
            w.rom  = (d <= 9) ? 17'(d * 8 + p) : 17'd0;
            w.data = ((d <= 9) && font(w.rom)) ? fg : bg;
            wq.push_back(w);
        end
    endtask

    task automatic run(input logic [15:0] bcd, input logic f,
                       input logic [11:0] fg, input logic [11:0] bg,
                       input logic [3:0] mask, input bit glitch);
        int n;
        int base;
        int k;
        n = 0;
        for (int s = 0; s < 4; s++) begin
            if (mask[s]) begin
                push_slot(s, bcd, fg, bg, 8);
                n++;
            end
        end
        dq.push_back(2 + 9 * n);
        base = done_cnt;
        @(negedge clk);
        bcd_in    = bcd;
        force_all = f;
        fg_color  = fg;
        bg_color  = bg;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_load", 32'(busy), 32'd1);
        k = 0;
        while (done_cnt == base && k < 100) begin
            @(negedge clk);
            #1;
            k++;
            start = glitch && (k == 6);
        end
        if (done_cnt == base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none expected=%0d", 2 + 9 * n);
        end
        start = glitch;
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("busy_after", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'(base + 1));
        chk("writes_left", 32'(wq.size()), 32'd0);
        force_all = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        force_all = 1'b0;
        bcd_in    = '0;
        fg_color  = '0;
        bg_color  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_rom", 32'(rom_addr), 32'd0);
        chk("rst_fbaddr", 32'(fb_addr), 32'd0);
        chk("rst_wdata", 32'(fb_wdata), 32'd0);
        rst = 1'b0;

        run(16'h1234, 1'b0, 12'hFFF, 12'h000, 4'b1111, 1'b0);
        run(16'h1234, 1'b0, 12'hFFF, 12'h000, 4'b0000, 1'b0);
        run(16'h1294, 1'b0, 12'hFFF, 12'h000, 4'b0100, 1'b0);
        run(16'h12A4, 1'b0, 12'hFFF, 12'h000, 4'b0100, 1'b0);
        run(16'h12A4, 1'b1, 12'hABC, 12'h123, 4'b1111, 1'b1);

        push_slot(0, 16'h1234, 12'h0F0, 12'h00F, 8);
        push_slot(1, 16'h1234, 12'h0F0, 12'h00F, 2);
        @(negedge clk);
        bcd_in    = 16'h1234;
        force_all = 1'b1;
        fg_color  = 12'h0F0;
        bg_color  = 12'h00F;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_we", 32'(fb_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        rst       = 1'b0;
        force_all = 1'b0;
        @(negedge clk);
        chk("rst_mid_left", 32'(wq.size()), 32'd0);

        run(16'h1234, 1'b0, 12'hFFF, 12'h000, 4'b1111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
